// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, issues one imem read per cycle and
// buffers returned instructions for decode, with taken-branch redirect and halt.
module fetch_controller #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 24,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_pc,
  input  logic [ADDR_W-1:0]  br_imm,
  input  logic               halt,
  output logic               busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {RUN, REDIRECT, HALTED} state_t;

  state_t              state, next_state;
  logic [ADDR_W-1:0]   fetch_pc;
  logic [ADDR_W-1:0]   inflight_pc;
  logic                inflight;
  logic [INSTR_W-1:0]  entry_instr [DEPTH];
  logic [ADDR_W-1:0]   entry_pc    [DEPTH];
  logic [PW-1:0]       head, tail;
  logic [CW-1:0]       count;
  logic [CW:0]         occupancy;
  logic                pop, issue, wr_en;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= next_state;
  end

  // A taken branch wins over halt from every state.
  always_comb begin
    next_state = state;
    case (state)
      RUN: begin
        if (br_taken)  next_state = REDIRECT;
        else if (halt) next_state = HALTED;
      end
      HALTED: begin
        if (br_taken)   next_state = REDIRECT;
        else if (!halt) next_state = RUN;
      end
      REDIRECT: begin
        if (br_taken)  next_state = REDIRECT;
        else if (halt) next_state = HALTED;
        else           next_state = RUN;
      end
      default: next_state = RUN;
    endcase
  end

  // Issue only if the slot freed by this cycle's pop leaves room for the new read.
  always_comb begin
    pop       = instr_valid & instr_ready;
    occupancy = {1'b0, count} - (CW+1)'(pop) + (CW+1)'(inflight);
    issue     = 1'b0;
    wr_en     = 1'b0;
    if (!reset && !br_taken && !halt && (state != HALTED) &&
        (occupancy < (CW+1)'(DEPTH)))
      issue = 1'b1;
    if (inflight && !br_taken && (state != REDIRECT))
      wr_en = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 1'b1;
      end
      if (br_taken) begin
        fetch_pc <= br_pc + br_imm;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
      end else begin
        if (wr_en) begin
          entry_instr[tail] <= imem_rdata;
          entry_pc[tail]    <= inflight_pc;
          tail              <= next_ptr(tail);
        end
        if (pop) head <= next_ptr(head);
        count <= count + CW'(wr_en) - CW'(pop);
      end
    end
  end

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? entry_instr[head] : '0;
  assign instr_pc    = instr_valid ? entry_pc[head] : '0;
  assign imem_en     = issue;
  assign imem_addr   = fetch_pc;
  assign busy        = inflight | instr_valid;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: a queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fetch_controller;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 24;
  localparam int DEPTH   = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               imem_en;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata = '0;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;
  logic               br_taken;
  logic [ADDR_W-1:0]  br_pc;
  logic [ADDR_W-1:0]  br_imm;
  logic               halt;
  logic               busy;

  always #5 clk = ~clk;

  fetch_controller #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .br_taken(br_taken), .br_pc(br_pc),
    .br_imm(br_imm), .halt(halt), .busy(busy)
  );

  function automatic logic [INSTR_W-1:0] memWord(input logic [ADDR_W-1:0] a);
    return {a ^ 8'h5A, 8'hC3, a};
  endfunction

  // Synchronous instruction memory: data one cycle after the strobe.
  always @(posedge clk) if (imem_en) imem_rdata <= memWord(imem_addr);

  int checks = 0;
  int passes = 0;

  // Reference model: delivered-order queue of pcs plus one pending read.
  int  mq[$];
  bit  mPend;
  int  mPendPc;
  int  mFetch;
  bit  mHaltedLast;
  bit  mBrLast;
  bit  modelKnown = 1'b0;
  bit  expIssue;
  bit  expPop;

  logic               capEn, capValid, capBusy;
  logic [ADDR_W-1:0]  capAddr, capPc;
  logic [INSTR_W-1:0] capInstr;
  int                 delivered[$];
  int                 enCount;
  int                 firstAddr;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  task automatic compareCycle();
    int occ;
    capEn    = imem_en;
    capAddr  = imem_addr;
    capValid = instr_valid;
    capPc    = instr_pc;
    capInstr = instr;
    capBusy  = busy;
    if (capEn) enCount++;
    if (capValid && instr_ready) delivered.push_back(int'(capPc));
    expPop   = (mq.size() != 0) && instr_ready;
    occ      = mq.size() - int'(expPop) + int'(mPend);
    expIssue = !reset && !br_taken && !halt && !mHaltedLast && (occ < DEPTH);
    if (modelKnown) begin
      checkOutput("imem_en", 32'(imem_en), 32'(expIssue));
      if (expIssue) checkOutput("imem_addr", 32'(imem_addr), mFetch);
      checkOutput("instr_valid", 32'(instr_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        checkOutput("instr_pc", 32'(instr_pc), mq[0]);
        checkOutput("instr", 32'(instr), 32'(memWord(ADDR_W'(mq[0]))));
      end
      checkOutput("busy", 32'(busy), 32'(mPend || (mq.size() != 0)));
    end
  endtask

  task automatic updateModel();
    if (reset) begin
      mq.delete();
      mPend       = 1'b0;
      mPendPc     = 0;
      mFetch      = 0;
      mHaltedLast = 1'b0;
      mBrLast     = 1'b0;
      modelKnown  = 1'b1;
    end else begin
      if (expPop) mq.delete(0);
      if (mPend && !mBrLast && !br_taken) mq.push_back(mPendPc);
      if (br_taken) mq.delete();
      mPend = expIssue;
      if (expIssue) begin
        mPendPc = mFetch;
        mFetch  = (mFetch + 1) % 256;
      end
      if (br_taken) mFetch = (int'(br_pc) + int'(br_imm)) % 256;
      mHaltedLast = halt && !br_taken;
      mBrLast     = br_taken;
    end
  endtask

  // One cycle: drive after the falling edge, sample 1ns later, advance the model on the rising edge.
  task automatic applyStimulus(input logic r, input logic rdy, input logic br,
                               input logic [ADDR_W-1:0] bpc, input logic [ADDR_W-1:0] bimm,
                               input logic h);
    reset       = r;
    instr_ready = rdy;
    br_taken    = br;
    br_pc       = bpc;
    br_imm      = bimm;
    halt        = h;
    #1;
    compareCycle();
    @(posedge clk);
    updateModel();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] fetch_controller bench starting");
    applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("reset_en", 32'(capEn), 0);
    checkOutput("reset_addr", 32'(capAddr), 0);
    checkOutput("reset_valid", 32'(capValid), 0);
    checkOutput("reset_instr", 32'(capInstr), 0);
    checkOutput("reset_busy", 32'(capBusy), 0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0);
      if (i == 0) begin
        checkOutput("first_en", 32'(capEn), 1);
        checkOutput("first_addr", 32'(capAddr), 0);
      end
      if (i == 2) begin
        checkOutput("first_valid", 32'(capValid), 1);
        checkOutput("first_pc", 32'(capPc), 0);
      end
      if (i == 6) checkOutput("stream_pc", 32'(capPc), 4);
    end

    applyStimulus(0, 1, 1, 8'd3, 8'd5, 0);
    checkOutput("br_en_off", 32'(capEn), 0);
    delivered.delete();
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0);
      if (i == 1) checkOutput("br_target_addr", 32'(capAddr), 8);
      if (i == 2) checkOutput("br_bubble_valid", 32'(capValid), 0);
      if (i == 3) begin
        checkOutput("br_target_valid", 32'(capValid), 1);
        checkOutput("br_target_pc", 32'(capPc), 8);
      end
    end
    checkOutput("br_first_delivered", delivered[0], 8);

    applyStimulus(1, 0, 0, 0, 0, 0);
    enCount = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      if (i == 0) checkOutput("bp_addr0", 32'(capAddr), 0);
      if (i == 1) checkOutput("bp_addr1", 32'(capAddr), 1);
    end
    checkOutput("bp_reads", enCount, 2);
    delivered.delete();
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("bp_d0", delivered[0], 0);
    checkOutput("bp_d1", delivered[1], 1);
    checkOutput("bp_d2", delivered[2], 2);

    applyStimulus(0, 1, 1, 8'd250, 8'd10, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("wrap_target_addr", 32'(capAddr), 4);

    applyStimulus(0, 1, 1, 8'd250, 8'd2, 0);
    delivered.delete();
    for (int i = 1; i <= 9; i++) applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("wrap_d252", delivered[0], 252);
    checkOutput("wrap_d255", delivered[3], 255);
    checkOutput("wrap_d0", delivered[4], 0);

    applyStimulus(0, 1, 1, 8'h40, 8'h00, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, 0, 0);
    enCount = 0;
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 0, 1);
    checkOutput("halt_no_issue", enCount, 0);
    checkOutput("halt_busy_low", 32'(capBusy), 0);
    firstAddr = -1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0);
      if (i == 0) checkOutput("halt_release_wait", 32'(capEn), 0);
      if (capEn && firstAddr < 0) firstAddr = int'(capAddr);
    end
    checkOutput("halt_resume_addr", firstAddr, 32'h46);

    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0);
      if (i == 0) begin
        checkOutput("rst_mid_en", 32'(capEn), 1);
        checkOutput("rst_mid_addr", 32'(capAddr), 0);
        checkOutput("rst_mid_valid", 32'(capValid), 0);
        checkOutput("rst_mid_busy", 32'(capBusy), 0);
        checkOutput("rst_mid_pc", 32'(capPc), 0);
      end
      if (i == 1) checkOutput("rst_mid_stale", 32'(capValid), 0);
      if (i == 2) checkOutput("rst_mid_restart_pc", 32'(capPc), 0);
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Instruction-fetch sequencer between the instruction memory and the decode stage. It owns the 8-bit program counter and issues one read per cycle to the synchronous instruction memory. Returned 24-bit instructions are held in a small skid buffer and handed to decode over a valid/ready handshake. It also handles taken-branch redirects (PC = branch PC + immediate), discarding wrong-path fetches and buffered instructions.

## Interface
- ADDR_W, 8, PC / instruction-memory address width
- INSTR_W, 24, instruction width
- DEPTH, 2, instruction buffer entries (≥2)

- CLK  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- imem_en  out  1  read strobe to instruction memory
- imem_addr  out  ADDR_W  read address; valid when imem_en=1
- imem_rdata  in  INSTR_W  read data, valid exactly one cycle after imem_en=1
- instr_valid  out  1  buffer head holds an instruction
- instr  out  INSTR_W  buffer head instruction
- instr_pc  out  ADDR_W  address of instr
- instr_ready  in  1  decode accepts head this cycle
- br_taken  in  1  one-cycle pulse: redirect fetch
- br_pc  in  ADDR_W  PC of the branch (from decode)
- br_imm  in  ADDR_W  branch immediate, unsigned
- halt  in  1  level: stop issuing new fetches
- busy  out  1  high while reads are in flight or buffer is non-empty

## Operation
- Registers: fetch_pc, buffer (instr + pc per entry, circular, count), inflight flag plus inflight pc, FSM state.
- FSM states:
  - RUN: normal issue.
  - REDIRECT: one cycle after br_taken.
  - HALTED: entered while halt=1.
- FSM transitions:
  - reset → RUN.
  - RUN → REDIRECT on br_taken.
  - RUN → HALTED on halt=1 with no br_taken.
  - HALTED → RUN when halt=0.
  - HALTED → REDIRECT on br_taken.
  - REDIRECT → RUN, or HALTED if halt=1.
- pop = instr_valid & instr_ready.
- Issue in RUN and REDIRECT when all hold: (count − pop + inflight) < DEPTH, halt=0, br_taken=0. Issue drives imem_en=1, imem_addr=fetch_pc; fetch_pc <= fetch_pc+1 (wraps 255→0).
- Response: the cycle after an issue, imem_rdata and inflight pc are written at the buffer tail. A write and a pop in the same cycle are both applied.
- Redirect (br_taken=1 in any state):
  - buffer count <= 0; any pop that cycle is accepted but irrelevant.
  - imem_en=0 that cycle.
  - fetch_pc <= br_pc + br_imm, truncated to ADDR_W (modular wrap).
  - State → REDIRECT. In REDIRECT the response of any read issued before the redirect is dropped, not written. REDIRECT may itself issue the target address.
- br_taken has priority over halt and over issue.
- halt: stops issuing only. In-flight responses are still written and the buffer still drains to decode.
- busy = inflight | (count≠0).
- instr/instr_pc are don't-care when instr_valid=0. The bench checks them only when valid.

## Timing
- Reset values: imem_en=0, imem_addr=0, instr_valid=0, instr=0, instr_pc=0, busy=0, fetch_pc=0, count=0, inflight=0, state=RUN.
- Reset asserted mid-operation clears everything at the next edge. A response arriving the cycle after reset is dropped.
- First cycle after reset deasserts: imem_en=1, imem_addr=0.
- Fetch-to-decode latency: issue at cycle t → data written at end of t+1 → instr_valid at t+2.
- Throughput: with instr_ready held high, one instruction per cycle in steady state. PC sequence is 0,1,2,… with no bubbles.
- Backpressure: with instr_ready=0, issue stops once count+inflight=DEPTH. No instruction is lost or duplicated.
- Redirect penalty: br_taken at cycle r → target issued at r+1 → target instr_valid at r+3. instr_valid=0 during r+1 and r+2.
- Wrap: fetch_pc 255 increments to 0. A branch target sum ≥256 wraps modulo 256.

## Test plan
- Reset then instr_ready=1, memory word[a]=a: imem_addr 0,1,2,… each cycle; instr_pc 0,1,2,… from cycle 2 with instr_valid continuously high.
- instr_ready=0 for 6 cycles after reset: exactly DEPTH=2 reads issued (addr 0,1), then imem_en=0. On release, instrs 0,1,2 are delivered in order with no gap or duplicate.
- br_taken with br_pc=3, br_imm=5 while streaming: buffer flushed; next imem_addr=8; next valid instr_pc=8 at r+3; no pc 4–7 delivered after r.
- br_pc=250, br_imm=10 → target 4. Separately, a sequential run through 255 wraps to instr_pc 0.
- halt=1 for 4 cycles mid-stream: imem_en=0 throughout; buffered instrs drain; busy falls to 0. After halt=0, fetch resumes at the next sequential pc.
- Reset asserted for one cycle while a read is in flight and the buffer holds 2 entries: all outputs at reset values next cycle; the stale response is not delivered; fetch restarts at addr 0.
